// File: rtl/rtmq_input_fifo_sr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rtmq_input_fifo_sr_pkg
//  Description : Shared constants for the RTMQ multi-frame input shift
//                register: regfile/ALU bus widths, ALU bus field positions,
//                status word bit positions and the packed status layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package rtmq_input_fifo_sr_pkg;

    // Regfile and ALU bus widths (mirrors RTMQ_Peripheral.v).
    localparam int W_REG = 32;
    localparam int W_ADR = 8;
    localparam int W_ALU = W_REG + W_ADR + 2;

    // ALU bus fields: data in the LSBs, then register address, read flag, write flag.
    localparam int ALU_ADR_LSB = W_REG;
    localparam int ALU_RD_BIT  = W_REG + W_ADR;
    localparam int ALU_WR_BIT  = W_REG + W_ADR + 1;

    // Status word bit positions, shared with software and the bench.
    localparam int STA_NE      = 0;
    localparam int STA_FULL    = 1;
    localparam int STA_OVF     = 2;
    localparam int STA_UDF     = 3;
    localparam int STA_CNT_LSB = 4;
    localparam int STA_CNT_W   = 12;
    localparam int STA_IDX_LSB = 16;
    localparam int STA_IDX_W   = 8;
    localparam int STA_W       = STA_IDX_LSB + STA_IDX_W;

    // Packed view of the status word; field order matches the STA_* positions.
    typedef struct packed {
        logic [STA_IDX_W-1:0] idx;
        logic [STA_CNT_W-1:0] cnt;
        logic                 udf;
        logic                 ovf;
        logic                 full;
        logic                 ne;
    } sta_t;

    // Width of a pointer/counter addressing n entries, never below one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/RTMQ_AcsFlg.sv
`default_nettype none
// ============================================================================
//  Module      : RTMQ_AcsFlg
//  Description : Decodes the ALU output bus into a single-cycle read request
//                flag for one regfile address.
//  Revision    : 1.0 - initial release
// ============================================================================
module RTMQ_AcsFlg
    import rtmq_input_fifo_sr_pkg::*;
#(
    parameter int ADDR = 0
) (
    input  logic [W_ALU-1:0] alu_out,
    output logic             f_req
);

    // Data payload and write flag are irrelevant to a read-side decoder.
    logic w_unused;
    assign w_unused = ^{alu_out[W_REG-1:0], alu_out[ALU_WR_BIT]};

    assign f_req = alu_out[ALU_RD_BIT] &&
                   (alu_out[ALU_ADR_LSB +: W_ADR] == W_ADR'(ADDR));

endmodule
`default_nettype wire

// File: rtl/rtmq_frame_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rtmq_frame_fifo
//  Description : DEPTH-entry frame FIFO with head/tail/count and a full
//                policy of either dropping the new frame or overwriting the
//                oldest. Exposes next-cycle head frame/count so the owner can
//                register its outputs with one cycle of latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module rtmq_frame_fifo
    import rtmq_input_fifo_sr_pkg::*;
#(
    parameter int W_FRM = 192,
    parameter int DEPTH = 4,
    parameter int OVW   = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W_FRM-1:0]           din,
    output logic                       full,
    output logic                       empty,
    output logic                       drop_oldest,
    output logic                       ovf_evt,
    output logic [$clog2(DEPTH+1)-1:0] cnt_nxt,
    output logic                       empty_nxt,
    output logic [W_FRM-1:0]           head_frm_nxt
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W_FRM-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_cnt;

    logic             w_pop_ok;
    logic             w_room;
    logic             w_push_ok;
    logic [PW-1:0]    w_head_nxt;
    logic [PW-1:0]    w_tail_nxt;
    logic [CW-1:0]    w_cnt_nxt;

    // Pointers wrap at DEPTH so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (r_cnt == CW'(DEPTH));
    assign empty = (r_cnt == '0);

    // Pop acts on pre-cycle contents first, so a same-cycle pop frees a slot for push.
    always_comb begin
        w_pop_ok    = pop && !empty;
        w_room      = !full || w_pop_ok;
        w_push_ok   = push && (w_room || (OVW != 0));
        drop_oldest = push && !w_room && (OVW != 0);
        ovf_evt     = push && !w_room;
        w_head_nxt  = (w_pop_ok || drop_oldest) ? ptr_inc(r_head) : r_head;
        w_tail_nxt  = w_push_ok ? ptr_inc(r_tail) : r_tail;
        w_cnt_nxt   = r_cnt;
        if (w_push_ok && !w_pop_ok && !drop_oldest) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end else if (!w_push_ok && w_pop_ok) begin
            w_cnt_nxt = r_cnt - 1'b1;
        end
    end

    // The slot written this cycle becomes the head only when the FIFO drains into it.
    assign head_frm_nxt = (w_push_ok && (r_tail == w_head_nxt)) ? din : r_mem[w_head_nxt];
    assign cnt_nxt      = w_cnt_nxt;
    assign empty_nxt    = (w_cnt_nxt == '0);

    // Frame storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (!rst && w_push_ok) begin
            r_mem[r_tail] <= din;
        end
    end

    // Head, tail and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
        end else begin
            r_head <= w_head_nxt;
            r_tail <= w_tail_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rtmq_input_fifo_sr.sv
`default_nettype none
// ============================================================================
//  Module      : rtmq_input_fifo_sr
//  Description : Multi-frame input shift register for the RTMQ regfile.
//                Buffers N_SRL-word frames in a DEPTH-frame FIFO, presents
//                the head frame word by word on reg_isr and exposes
//                occupancy, word index and sticky overflow/underflow on
//                reg_sta.
//  Revision    : 1.0 - initial release
// ============================================================================
module rtmq_input_fifo_sr
    import rtmq_input_fifo_sr_pkg::*;
#(
    parameter int ADDR     = 0,
    parameter int ADDR_STA = 1,
    parameter int N_SRL    = 6,
    parameter int DEPTH    = 4,
    parameter int OVW      = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [W_ALU-1:0]       alu_out,
    output logic [W_REG-1:0]       reg_isr,
    output logic [W_REG-1:0]       reg_sta,
    input  logic [W_REG*N_SRL-1:0] dat_in,
    input  logic                   f_load
);

    localparam int IW    = ptr_width(N_SRL);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int W_FRM = W_REG * N_SRL;

    // Parameter ranges that the status word can represent.
    if (N_SRL < 1 || N_SRL > 256) begin : g_err_n_srl
        $error("rtmq_input_fifo_sr: N_SRL must be in 1..256");
    end
    if (DEPTH < 1 || DEPTH >= 4096) begin : g_err_depth
        $error("rtmq_input_fifo_sr: DEPTH must be in 1..4095");
    end

    logic             w_rrq;
    logic             w_srq;
    logic             w_full;
    logic             w_empty;
    logic             w_drop;
    logic             w_ovf_evt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_empty_nxt;
    logic [W_FRM-1:0] w_frm_nxt;
    logic             w_rd_ok;
    logic             w_pop;
    logic [IW-1:0]    w_idx_nxt;
    logic             w_ovf_nxt;
    logic             w_udf_nxt;
    sta_t             w_sta_nxt;
    logic [W_REG-1:0] w_isr_nxt;
    logic [W_REG-1:0] w_words [N_SRL];

    logic [IW-1:0]    r_idx;
    logic             r_ovf;
    logic             r_udf;

    RTMQ_AcsFlg #(.ADDR(ADDR)) u_acs_dat (
        .alu_out (alu_out),
        .f_req   (w_rrq)
    );

    RTMQ_AcsFlg #(.ADDR(ADDR_STA)) u_acs_sta (
        .alu_out (alu_out),
        .f_req   (w_srq)
    );

    // A read pops the head frame only when it consumes the last word.
    assign w_rd_ok = w_rrq && !w_empty;
    assign w_pop   = w_rd_ok && (r_idx == IW'(N_SRL - 1));

    rtmq_frame_fifo #(
        .W_FRM (W_FRM),
        .DEPTH (DEPTH),
        .OVW   (OVW)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (f_load),
        .pop          (w_pop),
        .din          (dat_in),
        .full         (w_full),
        .empty        (w_empty),
        .drop_oldest  (w_drop),
        .ovf_evt      (w_ovf_evt),
        .cnt_nxt      (w_cnt_nxt),
        .empty_nxt    (w_empty_nxt),
        .head_frm_nxt (w_frm_nxt)
    );

    // Split the next head frame into words, word 0 in the LSBs.
    for (genvar gi = 0; gi < N_SRL; gi++) begin : g_word
        assign w_words[gi] = w_frm_nxt[gi*W_REG +: W_REG];
    end

    // Next word index, sticky flags (set beats clear) and the next output words.
    always_comb begin
        w_idx_nxt = r_idx;
        if (w_drop || w_pop) begin
            w_idx_nxt = '0;
        end else if (w_rd_ok) begin
            w_idx_nxt = r_idx + 1'b1;
        end
        w_ovf_nxt      = (r_ovf && !w_srq) || w_ovf_evt;
        w_udf_nxt      = (r_udf && !w_srq) || (w_rrq && w_empty);
        w_isr_nxt      = w_empty_nxt ? '0 : w_words[w_idx_nxt];
        w_sta_nxt      = '0;
        w_sta_nxt.ne   = !w_empty_nxt;
        w_sta_nxt.full = (w_cnt_nxt == CW'(DEPTH));
        w_sta_nxt.ovf  = w_ovf_nxt;
        w_sta_nxt.udf  = w_udf_nxt;
        w_sta_nxt.cnt  = STA_CNT_W'(w_cnt_nxt);
        w_sta_nxt.idx  = STA_IDX_W'(w_idx_nxt);
    end

    // Word index, sticky flags and the registered regfile outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
            reg_isr <= '0;
            reg_sta <= '0;
        end else begin
            r_idx   <= w_idx_nxt;
            r_ovf   <= w_ovf_nxt;
            r_udf   <= w_udf_nxt;
            reg_isr <= w_isr_nxt;
            reg_sta <= W_REG'(w_sta_nxt);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rtmq_input_fifo_sr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rtmq_input_fifo_sr
//  Description : Directed self-checking bench for rtmq_input_fifo_sr with
//                N_SRL=3, DEPTH=2; one instance per full policy, both fed
//                the same stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rtmq_input_fifo_sr;
    import rtmq_input_fifo_sr_pkg::*;

    localparam int N_SRL = 3;
    localparam int DEPTH = 2;
    localparam int OP_NONE = 0;
    localparam int OP_RD   = 1;
    localparam int OP_SR   = 2;

    localparam logic [95:0] F1 = {32'h33, 32'h22, 32'h11};
    localparam logic [95:0] FA = {32'hA2, 32'hA1, 32'hA0};
    localparam logic [95:0] FB = {32'hB2, 32'hB1, 32'hB0};
    localparam logic [95:0] FC = {32'hC2, 32'hC1, 32'hC0};

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic [W_ALU-1:0]       alu_out = '0;
    logic [W_REG*N_SRL-1:0] dat_in = '0;
    logic                   f_load = 1'b0;
    logic [W_REG-1:0]       isr_d, sta_d, isr_o, sta_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rtmq_input_fifo_sr #(.ADDR(0), .ADDR_STA(1), .N_SRL(N_SRL), .DEPTH(DEPTH), .OVW(0)) u_dut_drop (
        .clk(clk), .rst(rst), .alu_out(alu_out), .reg_isr(isr_d), .reg_sta(sta_d),
        .dat_in(dat_in), .f_load(f_load)
    );

    rtmq_input_fifo_sr #(.ADDR(0), .ADDR_STA(1), .N_SRL(N_SRL), .DEPTH(DEPTH), .OVW(1)) u_dut_ovw (
        .clk(clk), .rst(rst), .alu_out(alu_out), .reg_isr(isr_o), .reg_sta(sta_o),
        .dat_in(dat_in), .f_load(f_load)
    );

    // Drive one cycle of stimulus; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic ld, input logic [95:0] frm, input int op);
        f_load  = ld;
        dat_in  = frm;
        alu_out = '0;
        if (op == OP_RD) begin
            alu_out[ALU_RD_BIT] = 1'b1;
            alu_out[ALU_ADR_LSB +: W_ADR] = 8'd0;
        end else if (op == OP_SR) begin
            alu_out[ALU_RD_BIT] = 1'b1;
            alu_out[ALU_ADR_LSB +: W_ADR] = 8'd1;
        end
        @(posedge clk);
        #1;
        f_load  = 1'b0;
        alu_out = '0;
    endtask

    // Reset with a load and a data read asserted, which reset must override.
    task automatic do_reset();
        rst = 1'b1;
        step(1'b1, FA, OP_RD);
        step(1'b1, FB, OP_RD);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (isr_d !== 32'h0) begin n_err++; $display("FAIL reset_isr_drop got=%h exp=%h", isr_d, 32'h0); end
        n_cmp++; if (sta_d !== 32'h0) begin n_err++; $display("FAIL reset_sta_drop got=%h exp=%h", sta_d, 32'h0); end
        n_cmp++; if (isr_o !== 32'h0) begin n_err++; $display("FAIL reset_isr_ovw got=%h exp=%h", isr_o, 32'h0); end
        n_cmp++; if (sta_o !== 32'h0) begin n_err++; $display("FAIL reset_sta_ovw got=%h exp=%h", sta_o, 32'h0); end
        step(1'b0, '0, OP_NONE);
        n_cmp++; if (sta_d !== 32'h0) begin n_err++; $display("FAIL reset_no_load got=%h exp=%h", sta_d, 32'h0); end
    endtask

    task automatic test_basic_frame();
        do_reset();
        step(1'b1, F1, OP_NONE);
        n_cmp++; if (isr_d !== 32'h11) begin n_err++; $display("FAIL basic_w0 got=%h exp=%h", isr_d, 32'h11); end
        // ne | cnt=1
        n_cmp++; if (sta_d !== 32'h11) begin n_err++; $display("FAIL basic_sta0 got=%h exp=%h", sta_d, 32'h11); end
        step(1'b0, '0, OP_RD);
        n_cmp++; if (isr_d !== 32'h22) begin n_err++; $display("FAIL basic_w1 got=%h exp=%h", isr_d, 32'h22); end
        // ne | cnt=1 | idx=1
        n_cmp++; if (sta_d !== 32'h10011) begin n_err++; $display("FAIL basic_sta1 got=%h exp=%h", sta_d, 32'h10011); end
        step(1'b0, '0, OP_RD);
        n_cmp++; if (isr_d !== 32'h33) begin n_err++; $display("FAIL basic_w2 got=%h exp=%h", isr_d, 32'h33); end
        step(1'b0, '0, OP_RD);
        n_cmp++; if (isr_d !== 32'h0) begin n_err++; $display("FAIL basic_empty_isr got=%h exp=%h", isr_d, 32'h0); end
        n_cmp++; if (sta_d !== 32'h0) begin n_err++; $display("FAIL basic_empty_sta got=%h exp=%h", sta_d, 32'h0); end
    endtask

    task automatic test_full_drop();
        do_reset();
        step(1'b1, FA, OP_NONE);
        step(1'b1, FB, OP_NONE);
        // ne | full | cnt=2
        n_cmp++; if (sta_d !== 32'h23) begin n_err++; $display("FAIL drop_full_sta got=%h exp=%h", sta_d, 32'h23); end
        step(1'b1, FC, OP_NONE);
        n_cmp++; if (isr_d !== 32'hA0) begin n_err++; $display("FAIL drop_head got=%h exp=%h", isr_d, 32'hA0); end
        n_cmp++; if (sta_d !== 32'h27) begin n_err++; $display("FAIL drop_ovf_sta got=%h exp=%h", sta_d, 32'h27); end
        n_cmp++; if (isr_o !== 32'hB0) begin n_err++; $display("FAIL ovw_head_b got=%h exp=%h", isr_o, 32'hB0); end
        n_cmp++; if (sta_o !== 32'h27) begin n_err++; $display("FAIL ovw_ovf_sta got=%h exp=%h", sta_o, 32'h27); end
        step(1'b0, '0, OP_SR);
        n_cmp++; if (sta_d !== 32'h23) begin n_err++; $display("FAIL drop_sta_clear got=%h exp=%h", sta_d, 32'h23); end
        n_cmp++; if (sta_o !== 32'h23) begin n_err++; $display("FAIL ovw_sta_clear got=%h exp=%h", sta_o, 32'h23); end
        n_cmp++; if (isr_d !== 32'hA0) begin n_err++; $display("FAIL drop_sr_no_adv got=%h exp=%h", isr_d, 32'hA0); end
    endtask

    task automatic test_full_overwrite();
        do_reset();
        step(1'b1, FA, OP_NONE);
        step(1'b1, FB, OP_NONE);
        step(1'b0, '0, OP_RD);
        n_cmp++; if (isr_o !== 32'hA1) begin n_err++; $display("FAIL ovw_a1 got=%h exp=%h", isr_o, 32'hA1); end
        step(1'b1, FC, OP_NONE);
        n_cmp++; if (isr_o !== 32'hB0) begin n_err++; $display("FAIL ovw_b0 got=%h exp=%h", isr_o, 32'hB0); end
        // ne | full | ovf | cnt=2 | idx=0
        n_cmp++; if (sta_o !== 32'h27) begin n_err++; $display("FAIL ovw_sta got=%h exp=%h", sta_o, 32'h27); end
        n_cmp++; if (isr_d !== 32'hA1) begin n_err++; $display("FAIL drop_keep_a1 got=%h exp=%h", isr_d, 32'hA1); end
        n_cmp++; if (sta_d !== 32'h10027) begin n_err++; $display("FAIL drop_sta_idx1 got=%h exp=%h", sta_d, 32'h10027); end
        step(1'b0, '0, OP_RD);
        step(1'b0, '0, OP_RD);
        step(1'b0, '0, OP_RD);
        n_cmp++; if (isr_o !== 32'hC0) begin n_err++; $display("FAIL ovw_c0 got=%h exp=%h", isr_o, 32'hC0); end
        // ne | ovf | cnt=1
        n_cmp++; if (sta_o !== 32'h15) begin n_err++; $display("FAIL ovw_c0_sta got=%h exp=%h", sta_o, 32'h15); end
        n_cmp++; if (isr_d !== 32'hB1) begin n_err++; $display("FAIL drop_b1 got=%h exp=%h", isr_d, 32'hB1); end
    endtask

    task automatic test_underflow();
        do_reset();
        step(1'b0, '0, OP_RD);
        n_cmp++; if (isr_d !== 32'h0) begin n_err++; $display("FAIL udf_isr got=%h exp=%h", isr_d, 32'h0); end
        n_cmp++; if (sta_d !== 32'h8) begin n_err++; $display("FAIL udf_sta got=%h exp=%h", sta_d, 32'h8); end
        // Status read clears udf while the load lands: ne | cnt=1
        step(1'b1, F1, OP_SR);
        n_cmp++; if (sta_d !== 32'h11) begin n_err++; $display("FAIL udf_clr_load_sta got=%h exp=%h", sta_d, 32'h11); end
        n_cmp++; if (isr_d !== 32'h11) begin n_err++; $display("FAIL udf_clr_load_isr got=%h exp=%h", isr_d, 32'h11); end
        do_reset();
        // Read on empty with a same-cycle load: ne | udf | cnt=1
        step(1'b1, FA, OP_RD);
        n_cmp++; if (sta_d !== 32'h19) begin n_err++; $display("FAIL udf_with_load_sta got=%h exp=%h", sta_d, 32'h19); end
        n_cmp++; if (isr_d !== 32'hA0) begin n_err++; $display("FAIL udf_with_load_isr got=%h exp=%h", isr_d, 32'hA0); end
    endtask

    task automatic test_pop_load();
        do_reset();
        step(1'b1, FA, OP_NONE);
        step(1'b1, FB, OP_NONE);
        step(1'b0, '0, OP_RD);
        step(1'b0, '0, OP_RD);
        n_cmp++; if (sta_d !== 32'h20023) begin n_err++; $display("FAIL popld_pre_sta got=%h exp=%h", sta_d, 32'h20023); end
        step(1'b1, FC, OP_RD);
        n_cmp++; if (sta_d !== 32'h23) begin n_err++; $display("FAIL popld_sta_drop got=%h exp=%h", sta_d, 32'h23); end
        n_cmp++; if (sta_o !== 32'h23) begin n_err++; $display("FAIL popld_sta_ovw got=%h exp=%h", sta_o, 32'h23); end
        n_cmp++; if (isr_d !== 32'hB0) begin n_err++; $display("FAIL popld_b0 got=%h exp=%h", isr_d, 32'hB0); end
        step(1'b0, '0, OP_RD);
        step(1'b0, '0, OP_RD);
        n_cmp++; if (isr_d !== 32'hB2) begin n_err++; $display("FAIL popld_b2 got=%h exp=%h", isr_d, 32'hB2); end
        step(1'b0, '0, OP_RD);
        n_cmp++; if (isr_d !== 32'hC0) begin n_err++; $display("FAIL popld_c0 got=%h exp=%h", isr_d, 32'hC0); end
        n_cmp++; if (sta_d !== 32'h11) begin n_err++; $display("FAIL popld_c0_sta got=%h exp=%h", sta_d, 32'h11); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(1'b1, FA, OP_NONE);
        step(1'b1, FB, OP_NONE);
        step(1'b0, '0, OP_RD);
        step(1'b1, FC, OP_NONE);
        n_cmp++; if (sta_d !== 32'h10027) begin n_err++; $display("FAIL rstmid_pre_sta got=%h exp=%h", sta_d, 32'h10027); end
        rst = 1'b1;
        step(1'b1, F1, OP_RD);
        rst = 1'b0;
        n_cmp++; if (isr_d !== 32'h0) begin n_err++; $display("FAIL rstmid_isr got=%h exp=%h", isr_d, 32'h0); end
        n_cmp++; if (sta_d !== 32'h0) begin n_err++; $display("FAIL rstmid_sta got=%h exp=%h", sta_d, 32'h0); end
        n_cmp++; if (sta_o !== 32'h0) begin n_err++; $display("FAIL rstmid_sta_ovw got=%h exp=%h", sta_o, 32'h0); end
        step(1'b1, F1, OP_NONE);
        n_cmp++; if (isr_d !== 32'h11) begin n_err++; $display("FAIL rstmid_reload_isr got=%h exp=%h", isr_d, 32'h11); end
        n_cmp++; if (sta_d !== 32'h11) begin n_err++; $display("FAIL rstmid_reload_sta got=%h exp=%h", sta_d, 32'h11); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic_frame();
        test_full_drop();
        test_full_overwrite();
        test_underflow();
        test_pop_load();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
